// File: rtl/alu_arbitro.sv
// alu_arbitro: two-requester round-robin arbiter and sequencer in front of a
// shared combinational ALU (AND/OR/ADD/SUB/SLT/NOR, 4-bit OP, zero flag).
// It accepts one operation at a time, registers its operands and OP into the
// ALU, captures the ALU result one cycle later, and returns the result to the
// granted requester over a valid/ready response channel.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   rN_valid/rN_ready        request handshake, N = 0,1 (ready is combinational)
//   rN_dato1/rN_dato2/rN_op  request operands and ALU OP code
//   rN_resp_valid/ready      response handshake towards requester N
//   rN_resp_dato/rN_resp_zf  result and zero flag (0 for the non-granted side)
//   rN_resp_err              only with ALU_OP_CHECK_EN: OP was rejected
//   alu_dato1/2, alu_op      registered ALU inputs, held between operations
//   alu_datoOut, alu_zf      combinational ALU outputs
//   busy                     an operation is in flight (state != IDLE)
//   grant_id                 requester currently or last granted
//
// Optional feature macro: ALU_OP_CHECK_EN. When defined, OPs outside the set
// the ALU implements are answered directly with err=1 instead of executing.
module alu_arbitro #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_dato1,
  input  logic [WIDTH-1:0] r0_dato2,
  input  logic [3:0]       r0_op,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [WIDTH-1:0] r0_resp_dato,
  output logic             r0_resp_zf,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_dato1,
  input  logic [WIDTH-1:0] r1_dato2,
  input  logic [3:0]       r1_op,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r1_resp_dato,
  output logic             r1_resp_zf,
  output logic [WIDTH-1:0] alu_dato1,
  output logic [WIDTH-1:0] alu_dato2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_datoOut,
  input  logic             alu_zf,
`ifdef ALU_OP_CHECK_EN
  output logic             r0_resp_err,
  output logic             r1_resp_err,
`endif
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_dato;
  logic             resp_zf;
  logic             sel;
  logic             accept;
  logic [WIDTH-1:0] req_dato1;
  logic [WIDTH-1:0] req_dato2;
  logic [3:0]       req_op;
  logic             resp_take;

`ifdef ALU_OP_CHECK_EN
  logic resp_err;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
           (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1100);
  endfunction
`endif

  // Tie goes to the requester that was not granted last; a lone request wins.
  always_comb begin
    if (r0_valid && r1_valid) sel = ~last_grant;
    else                      sel = ~r0_valid;
  end

  assign r0_ready  = (state == IDLE) && r0_valid && !sel;
  assign r1_ready  = (state == IDLE) && r1_valid && sel;
  assign accept    = r0_ready || r1_ready;
  assign req_dato1 = sel ? r1_dato1 : r0_dato1;
  assign req_dato2 = sel ? r1_dato2 : r0_dato2;
  assign req_op    = sel ? r1_op    : r0_op;
  assign resp_take = grant_id ? r1_resp_ready : r0_resp_ready;

  // The response registers are shared; each side only sees them when granted.
  assign r0_resp_valid = resp_valid && !grant_id;
  assign r1_resp_valid = resp_valid && grant_id;
  assign r0_resp_dato  = grant_id ? '0 : resp_dato;
  assign r1_resp_dato  = grant_id ? resp_dato : '0;
  assign r0_resp_zf    = resp_zf && !grant_id;
  assign r1_resp_zf    = resp_zf && grant_id;
`ifdef ALU_OP_CHECK_EN
  assign r0_resp_err   = resp_err && !grant_id;
  assign r1_resp_err   = resp_err && grant_id;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      alu_dato1  <= '0;
      alu_dato2  <= '0;
      alu_op     <= 4'b0000;
      resp_valid <= 1'b0;
      resp_dato  <= '0;
      resp_zf    <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id   <= sel;
            last_grant <= sel;
            busy       <= 1'b1;
`ifdef ALU_OP_CHECK_EN
            if (!op_legal(req_op)) begin
              // Rejected OP: the ALU inputs are left untouched.
              resp_dato  <= '0;
              resp_zf    <= 1'b0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              alu_dato1 <= req_dato1;
              alu_dato2 <= req_dato2;
              alu_op    <= req_op;
              resp_err  <= 1'b0;
              state     <= EXEC;
            end
`else
            alu_dato1 <= req_dato1;
            alu_dato2 <= req_dato2;
            alu_op    <= req_op;
            state     <= EXEC;
`endif
          end
        end
        EXEC: begin
          resp_dato  <= alu_datoOut;
          resp_zf    <= alu_zf;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbitro.md
Name: alu_arbitro

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU (AND/OR/ADD/SUB/SLT/NOR, 4-bit OP, ZF).
- Grants one operation at a time, drives registered operands and OP into the ALU, and captures datoOut/ZF one cycle later.
- Returns the result to the granted requester over a valid/ready response channel.
- Sits between the datapath requesters (e.g. main execute path, address-calc path) and the single ALU instance.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rN_valid  input  1  (N=0,1) request N valid
rN_ready  output  1  request N accepted this cycle
rN_dato1  input  WIDTH  request N operand A
rN_dato2  input  WIDTH  request N operand B
rN_op  input  4  request N ALU OP code
rN_resp_valid  output  1  result valid to requester N
rN_resp_ready  input  1  requester N takes result
rN_resp_dato  output  WIDTH  result to requester N
rN_resp_zf  output  1  zero flag to requester N
alu_dato1  output  WIDTH  registered ALU operand A
alu_dato2  output  WIDTH  registered ALU operand B
alu_op  output  4  registered ALU OP
alu_datoOut  input  WIDTH  ALU result
alu_zf  input  1  ALU zero flag
busy  output  1  state != IDLE
grant_id  output  1  requester currently or last granted

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1.
  - All alu_* outputs, resp_dato, resp_zf, resp_valid, busy and grant_id = 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE arbitration:
  - rN_ready is combinational and high only in IDLE, only for the chosen requester.
  - With one valid request, that requester is chosen.
  - With both valid, choose !last_grant (round-robin).
- Accept: on rN_valid && rN_ready:
  - Register dato1/dato2/op into alu_*.
  - grant_id=N, last_grant=N.
  - Go to EXEC.
- EXEC (1 cycle):
  - ALU inputs stable.
  - Capture alu_datoOut/alu_zf into the response registers.
  - Go to RESP.
- RESP:
  - r{grant_id}_resp_valid=1. The other requester's resp_valid stays 0.
  - Hold result and ZF stable until r{grant_id}_resp_ready=1, then go to IDLE the next cycle.
- Latency: accept at cycle T -> resp_valid at T+2. Minimum 3 cycles per operation (one op in flight, no overlap).
- Backpressure: resp_ready low holds RESP indefinitely. New requests are not accepted (rN_ready=0) during that time.
- alu_* hold their last values outside EXEC. They are not cleared after an operation.
- rN_resp_dato/zf are shared registers, gated: the non-granted requester sees 0.
- OP codes are passed through unchanged. Undefined OPs yield the ALU's default result 0, so ZF=1.
- Requester dropping valid before ready: no grant, no state change.
- Reset asserted mid-EXEC or mid-RESP:
  - Immediate return to reset values.
  - The in-flight result is discarded and no resp_valid is issued.

Optional Feature:
ALU_OP_CHECK_EN
- Defined:
  - Add outputs rN_resp_err (1 bit, reset 0).
  - At accept, an OP outside {0000,0001,0010,0110,0111,1100} is not sent to the ALU. Skip EXEC and go IDLE->RESP directly.
  - resp_dato=0, resp_zf=0, rN_resp_err=1. Latency T+1.
- Undefined:
  - No err ports. All OPs are executed by the ALU as in the base behaviour.

Test Plan:
1. Reset, r0 ADD (op 0010) 5+7, resp_ready=1 -> alu_op=0010 at T+1; r0_resp_valid at T+2 with dato=12, zf=0; busy low at T+3.
2. r1 SUB (0110) 9-9 -> r1_resp_dato=0, r1_resp_zf=1; r0_resp_valid stays 0 throughout.
3. From reset, r0 and r1 both valid continuously:
   - Grants alternate r0, r1, r0, r1.
   - r0 SLT (0111) 3<4 -> 1; r1 NOR (1100) 0,0 -> 0xFFFFFFFF, zf=0.
4. r0 AND request, r0_resp_ready held low 5 cycles -> resp_valid and dato held stable; r1_ready stays 0 while r1_valid=1; r1 granted the cycle after the RESP->IDLE return.
5. Assert rst_n low during EXEC -> all outputs 0 asynchronously; no resp_valid after release; next request proceeds normally with r0 winning a tie.
6. With ALU_OP_CHECK_EN, r0 op 0011 -> alu_op unchanged; r0_resp_valid at T+1 with err=1, dato=0. Without the macro -> ALU executes 0011, result 0, zf=1.
